// File: rtl/not_gate_bist.sv
// On-board stimulus/check sequencer for the not_gate inverter bank.
// Optional first-failure capture ports are enabled by defining NOT_GATE_BIST_FIRST_FAIL_EN.
module not_gate_bist #(
    parameter int WIDTH       = 1,
    parameter int HOLD_CYCLES = 30,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dut_y,
    output logic [WIDTH-1:0] dut_a,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] pattern_idx
`ifdef NOT_GATE_BIST_FIRST_FAIL_EN
    ,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_idx,
    output logic [WIDTH-1:0] fail_y
`endif
);

    // state | meaning
    // IDLE  | waiting for start after reset
    // RUN   | walking patterns, checking dut_y at the end of each hold window
    // DONE  | result held until the next accepted start or reset
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int               HC_W      = $clog2(HOLD_CYCLES + 1);
    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [WIDTH-1:0] PAT_LAST  = '1;
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [HC_W-1:0]  hold_q, hold_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             mismatch;
    logic             check;

`ifdef NOT_GATE_BIST_FIRST_FAIL_EN
    logic             fvld_q, fvld_d;
    logic [WIDTH-1:0] fidx_q, fidx_d;
    logic [WIDTH-1:0] fy_q, fy_d;
`endif

    assign mismatch = (dut_y != ~pat_q);
    assign check    = (hold_q == HOLD_LAST);

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        hold_d  = hold_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
`ifdef NOT_GATE_BIST_FIRST_FAIL_EN
        fvld_d  = fvld_q;
        fidx_d  = fidx_q;
        fy_d    = fy_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    pat_d   = '0;
                    hold_d  = '0;
                    err_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
`ifdef NOT_GATE_BIST_FIRST_FAIL_EN
                    fvld_d  = 1'b0;
                    fidx_d  = '0;
                    fy_d    = '0;
`endif
                end
            end
            RUN: begin
                hold_d = hold_q + HC_W'(1);
                if (check) begin
                    hold_d = '0;
                    if (mismatch && err_q != ERR_MAX) begin
                        err_d = err_q + ERR_W'(1);
                    end
`ifdef NOT_GATE_BIST_FIRST_FAIL_EN
                    if (mismatch && !fvld_q) begin
                        fvld_d = 1'b1;
                        fidx_d = pat_q;
                        fy_d   = dut_y;
                    end
`endif
                    if (pat_q == PAT_LAST) begin
                        // pass reflects err_d so the last pattern's check is included
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        pat_d = pat_q + WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            hold_q  <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
`ifdef NOT_GATE_BIST_FIRST_FAIL_EN
            fvld_q  <= 1'b0;
            fidx_q  <= '0;
            fy_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
`ifdef NOT_GATE_BIST_FIRST_FAIL_EN
            fvld_q  <= fvld_d;
            fidx_q  <= fidx_d;
            fy_q    <= fy_d;
`endif
        end
    end

    assign dut_a       = pat_q;
    assign pattern_idx = pat_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_count   = err_q;
`ifdef NOT_GATE_BIST_FIRST_FAIL_EN
    assign fail_valid  = fvld_q;
    assign fail_idx    = fidx_q;
    assign fail_y      = fy_q;
`endif

endmodule

// File: tb/tb_not_gate_bist.sv
// Directed bench for not_gate_bist: default build plus a WIDTH=2/HOLD=1 buffer-model instance.
module tb_not_gate_bist;

    logic       clk = 1'b0;
    logic       rst, start, fault;
    logic [0:0] dut_y, dut_a, pattern_idx;
    logic       busy, done, pass;
    logic [7:0] err_count;

    logic       start2;
    logic [1:0] dut_y2, dut_a2, pattern_idx2;
    logic       busy2, done2, pass2;
    logic [1:0] err_count2;

    int n_vec  = 0;
    int n_miss = 0;

`ifdef NOT_GATE_BIST_FIRST_FAIL_EN
    logic       fail_valid, fail_valid2;
    logic [0:0] fail_idx, fail_y;
    logic [1:0] fail_idx2, fail_y2;
`endif

    always #5 clk = ~clk;

    assign dut_y  = fault ? 1'b0 : ~dut_a;
    assign dut_y2 = dut_a2;

    not_gate_bist u_dut (
        .clk(clk), .rst(rst), .start(start), .dut_y(dut_y), .dut_a(dut_a),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .pattern_idx(pattern_idx)
`ifdef NOT_GATE_BIST_FIRST_FAIL_EN
        , .fail_valid(fail_valid), .fail_idx(fail_idx), .fail_y(fail_y)
`endif
    );

    not_gate_bist #(.WIDTH(2), .HOLD_CYCLES(1), .ERR_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .dut_y(dut_y2), .dut_a(dut_a2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
        .pattern_idx(pattern_idx2)
`ifdef NOT_GATE_BIST_FIRST_FAIL_EN
        , .fail_valid(fail_valid2), .fail_idx(fail_idx2), .fail_y(fail_y2)
`endif
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // start is sampled at the next edge (edge k); returns 1 time unit after it
    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; start2 = 1'b1; fault = 1'b0;
        #2;
        // 1: reset dominates start
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("rst_busy", busy, 0);
        end
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_dut_a", dut_a, 0);
        chk("rst_busy2", busy2, 0);
        rst = 1'b0; start = 1'b0; start2 = 1'b0;
        tick(2);
        chk("idle_busy", busy, 0);

        // 2: good inverter
        pulse_start();
        chk("good_busy_k", busy, 1);
        chk("good_a_k", dut_a, 0);
        tick(29);
        chk("good_a_k29", dut_a, 0);
        chk("good_done_k29", done, 0);
        tick(1);
        chk("good_a_k30", dut_a, 1);
        chk("good_idx_k30", pattern_idx, 1);
        tick(29);
        chk("good_a_k59", dut_a, 1);
        chk("good_done_k59", done, 0);
        tick(1);
        chk("good_done", done, 1);
        chk("good_busy", busy, 0);
        chk("good_err", err_count, 0);
        chk("good_pass", pass, 1);
        tick(5);
        chk("good_done_hold", done, 1);
        chk("good_a_hold", dut_a, 1);

        // 3: stuck-at-0 output
        fault = 1'b1;
        pulse_start();
        chk("sa0_restart_done", done, 0);
        chk("sa0_restart_pass", pass, 0);
        tick(60);
        chk("sa0_done", done, 1);
        chk("sa0_err", err_count, 1);
        chk("sa0_pass", pass, 0);
`ifdef NOT_GATE_BIST_FIRST_FAIL_EN
        chk("sa0_fvalid", fail_valid, 1);
        chk("sa0_fidx", fail_idx, 0);
        chk("sa0_fy", fail_y, 0);
`endif

        // 4b: restart from DONE with errors clears at the accepting edge
        fault = 1'b0;
        pulse_start();
        chk("rs_err_clr", err_count, 0);
        chk("rs_busy", busy, 1);
`ifdef NOT_GATE_BIST_FIRST_FAIL_EN
        chk("rs_fvalid_clr", fail_valid, 0);
`endif
        tick(60);
        chk("rs_done", done, 1);
        chk("rs_pass", pass, 1);

        // 4a: start during RUN is ignored
        pulse_start();
        tick(9);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("ign_a_k10", dut_a, 0);
        tick(20);
        chk("ign_a_k30", dut_a, 1);
        tick(29);
        chk("ign_done_k59", done, 0);
        tick(1);
        chk("ign_done_k60", done, 1);

        // 5: reset mid-run
        fault = 1'b1;
        pulse_start();
        tick(39);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        fault = 1'b0;
        chk("mr_a", dut_a, 0);
        chk("mr_busy", busy, 0);
        chk("mr_err", err_count, 0);
        chk("mr_done", done, 0);
        tick(80);
        chk("mr_no_done", done, 0);
        chk("mr_no_busy", busy, 0);

        // 6: WIDTH=2, HOLD=1, buffer model saturates ERR_W=2 counter
        start2 = 1'b1;
        tick(1);
        start2 = 1'b0;
        chk("w2_a0", dut_a2, 0);
        tick(1);
        chk("w2_a1", dut_a2, 1);
        chk("w2_err1", err_count2, 1);
        tick(1);
        chk("w2_a2", dut_a2, 2);
        tick(1);
        chk("w2_a3", dut_a2, 3);
        chk("w2_busy3", busy2, 1);
        chk("w2_err3", err_count2, 3);
        tick(1);
        chk("w2_done", done2, 1);
        chk("w2_err_sat", err_count2, 3);
        chk("w2_pass", pass2, 0);
        chk("w2_a_hold", dut_a2, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/not_gate_bist.md
Name: not_gate_bist

Overview:
Self-checking stimulus sequencer that sits directly upstream of the not_gate inverter and drives its input `a`. It also consumes the gate's output `y` on the return path. On a start pulse it walks every input pattern, holds each one for a programmable number of clocks, and checks the settled `y` against `~a`. It then reports an error count and a pass flag. It is the synthesizable, on-board counterpart of the inverter bench.

Parameters:
- WIDTH, 1: inverter bank width. Patterns run 0 .. 2^WIDTH-1.
- HOLD_CYCLES, 30: clocks each pattern is held (>=1).
- ERR_W, 8: width of the error counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to run the sequence.
- dut_y  in  WIDTH  output of the inverter under test.
- dut_a  out  WIDTH  drive to the inverter input.
- busy  out  1  high while a sequence runs.
- done  out  1  level; high from sequence end until the next accepted start or reset.
- pass  out  1  high with done when err_count==0; low otherwise.
- err_count  out  ERR_W  number of mismatching patterns.
- pattern_idx  out  WIDTH  pattern currently driven (equals dut_a).

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-high. It is sampled only on a rising `clk` edge; no asynchronous path.
- Reset values: state=IDLE, dut_a=0, pattern_idx=0, hold_cnt=0, busy=0, done=0, pass=0, err_count=0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at edge k:
  - at edge k: state=RUN, busy=1, done=0, pass=0, err_count=0, pattern=0, hold_cnt=0.
  - dut_a=0 is visible from edge k onward.
- RUN, every edge: hold_cnt increments.
- RUN, edge where hold_cnt==HOLD_CYCLES-1 (check edge):
  - sample dut_y and compare against ~pattern (all WIDTH bits).
  - any bit differing: err_count+1, saturating at 2^ERR_W-1 (no wrap).
  - if pattern==2^WIDTH-1: go to DONE, busy=0, done=1, pass=(final err_count==0). The final err_count includes this check. dut_a holds the last pattern.
  - otherwise: pattern+1, hold_cnt=0.
- Timing: total run time is 2^WIDTH*HOLD_CYCLES clocks. done rises at edge k+2^WIDTH*HOLD_CYCLES.
- Each pattern is driven for exactly HOLD_CYCLES clocks. dut_y is sampled only on the last clock of each hold window; mid-window glitches are not counted.
- start while RUN: ignored, with no effect on counters.
- DONE: outputs stay stable indefinitely. start restarts the run and clears err_count at the same edge.
- rst with start in the same cycle: rst wins; state is IDLE afterwards.
- rst mid-run: all registers return to reset values at that edge; no partial result is retained.
- HOLD_CYCLES=1: every clock is a check edge; pattern advances each cycle.
- WIDTH=1 gives the two patterns 0 then 1.
- hold_cnt width is clog2(HOLD_CYCLES+1), so hold_cnt never overflows.

Optional Feature:
- Macro: NOT_GATE_BIST_FIRST_FAIL_EN.
- Defined:
  - adds ports `fail_valid` out 1, `fail_idx` out WIDTH, `fail_y` out WIDTH.
  - on the first mismatching check edge of a run, capture pattern and dut_y, and set fail_valid=1.
  - later mismatches do not overwrite the capture.
  - all three ports clear on rst and on an accepted start.
- Undefined: the ports and capture registers are absent. All other behaviour is identical.

Test Plan:
1. Reset: hold rst=1 for 3 clocks with start=1 -> all outputs 0, state IDLE, busy never asserts.
2. Good inverter, defaults (dut_y=~dut_a), start pulse accepted at edge k -> dut_a=0 over k..k+29, dut_a=1 over k+30..k+59. At edge k+60: done=1, busy=0, err_count=0, pass=1.
3. Stuck-at-0 output (dut_y=0), defaults -> err_count=1, pass=0. With NOT_GATE_BIST_FIRST_FAIL_EN: fail_valid=1, fail_idx=0, fail_y=0.
4. Start handling: start pulsed at k+10 while RUN -> ignored, done still at k+60. start pulsed in DONE with a faulty dut_y first -> err_count clears to 0 at the accepting edge and the new run completes normally.
5. Reset mid-run: rst=1 at edge k+40 -> at k+40 dut_a=0, busy=0, err_count=0. No done pulse follows without a new start.
6. WIDTH=2, HOLD_CYCLES=1, ERR_W=2, buffer model (dut_y=dut_a) -> dut_a steps 0,1,2,3 on consecutive clocks. Four mismatches saturate err_count at 3; pass=0; done at k+4.
